// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus sequencer.
//   - state_e      : sequencer FSM encoding
//   - *_IDLE       : bus strobe levels while no transaction is running
//   - DW_DEF/T_PH_DEF : default bus width and strobe phase length
//   - REG_*        : RTC chip register addresses used by the client controllers
//   - next_phase() : successor of a timed bus phase
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_ADDR, S_GAP1, S_DATA, S_GAP2, S_ACK
  } state_e;

  localparam logic A_D_IDLE = 1'b1;
  localparam logic CS_IDLE  = 1'b1;
  localparam logic RD_IDLE  = 1'b1;
  localparam logic WR_IDLE  = 1'b1;

  localparam int DW_DEF   = 8;
  localparam int T_PH_DEF = 4;

  localparam logic [7:0] REG_SEC   = 8'h20;
  localparam logic [7:0] REG_MIN   = 8'h21;
  localparam logic [7:0] REG_HOUR  = 8'h22;
  localparam logic [7:0] REG_DAY   = 8'h23;
  localparam logic [7:0] REG_MONTH = 8'h24;
  localparam logic [7:0] REG_YEAR  = 8'h25;
  localparam logic [7:0] REG_TIMER = 8'h26;
  localparam logic [7:0] REG_CMD   = 8'h27;

  // The four timed phases run in a fixed order; GAP2 hands over to ACK.
  function automatic state_e next_phase(state_e s);
    case (s)
      S_ADDR:  return S_GAP1;
      S_GAP1:  return S_DATA;
      S_DATA:  return S_GAP2;
      default: return S_ACK;
    endcase
  endfunction

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// Client-side handshake and RTC pad-side bus of the sequencer.
//   client : req, we, addr, wdata (packed per channel at [i*DW +: DW]),
//            ack, rdata, grant_id, busy
//   pads   : a_d, cs, rd, wr, ad_out, ad_oe, ad_in
//   lock   : present only when RTC_SEQ_LOCK_EN is defined
// slave modport: the sequencer. master modport: clients + pads.
interface rtc_bus_sequencer_if #(
  parameter int N_CH = 4,
  parameter int DW   = 8
);
  localparam int GW = $clog2(N_CH);

  logic [N_CH-1:0]    req;
  logic [N_CH-1:0]    we;
  logic [N_CH*DW-1:0] addr;
  logic [N_CH*DW-1:0] wdata;
  logic [N_CH-1:0]    ack;
  logic [DW-1:0]      rdata;
  logic [GW-1:0]      grant_id;
  logic               busy;
  logic               a_d;
  logic               cs;
  logic               rd;
  logic               wr;
  logic [DW-1:0]      ad_out;
  logic               ad_oe;
  logic [DW-1:0]      ad_in;
`ifdef RTC_SEQ_LOCK_EN
  logic [N_CH-1:0]    lock;
`endif

  modport slave (
    input  req, we, addr, wdata, ad_in,
`ifdef RTC_SEQ_LOCK_EN
    input  lock,
`endif
    output ack, rdata, grant_id, busy, a_d, cs, rd, wr, ad_out, ad_oe
  );

  modport master (
    output req, we, addr, wdata, ad_in,
`ifdef RTC_SEQ_LOCK_EN
    output lock,
`endif
    input  ack, rdata, grant_id, busy, a_d, cs, rd, wr, ad_out, ad_oe
  );

endinterface

// File: rtl/rtc_bus_sequencer_rr_arbiter.sv
// Round-robin arbiter with optional sticky (lock) regrant.
//   req_i  : client requests          cur_i : client granted last
//   adv_i  : end-of-transaction strobe lock_i: that client's lock bit at adv_i
//   idle_i : sequencer idle            gnt_o/idx_o : one-hot and index of winner
// The pointer moves past cur_i on adv_i unless the client holds its lock.
module rr_arbiter #(
  parameter  int N_CH = 4,
  localparam int GW   = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req_i,
  input  logic [GW-1:0]   cur_i,
  input  logic            adv_i,
  input  logic            lock_i,
  input  logic            idle_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [GW-1:0]   idx_o
);
  logic [GW-1:0] ptr_q;
  logic          lock_q;
  logic          found;
  logic [GW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx_o = ptr_q;
    cand  = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = GW'((int'(ptr_q) + k) % N_CH);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    // A locked client that is still requesting wins regardless of the pointer.
    if (lock_q && req_i[cur_i]) begin
      found = 1'b1;
      idx_o = cur_i;
    end
    gnt_o = '0;
    if (found) gnt_o[idx_o] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      lock_q <= 1'b0;
    end else if (adv_i) begin
      lock_q <= lock_i;
      if (!lock_i) ptr_q <= (cur_i == GW'(N_CH - 1)) ? '0 : cur_i + GW'(1);
    end else if (idle_i && !req_i[cur_i]) begin
      // Lock only survives if the owner re-requests straight away.
      lock_q <= 1'b0;
    end
  end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// RTC bus sequencer: arbitrates N_CH clients onto the multiplexed RTC bus and
// generates a_d/cs/rd/wr timing (ADDR, GAP1, DATA, GAP2 of T_PH cycles each).
//   clk, reset : clock, async active-low reset
//   bus        : rtc_bus_sequencer_if.slave (client handshake + pad signals)
// Optional: define RTC_SEQ_LOCK_EN to add per-client lock (sticky regrant).
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DW   = DW_DEF,
  parameter int T_PH = T_PH_DEF
) (
  input logic             clk,
  input logic             reset,
  rtc_bus_sequencer_if.slave bus
);
  localparam int GW = $clog2(N_CH);
  localparam int CW = $clog2(T_PH) + 1;
  localparam logic [CW-1:0] LOAD = CW'(T_PH - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   grant_id_q, gnt_idx;
  logic [N_CH-1:0] gnt_oh;
  logic            we_q, we_sel;
  logic [DW-1:0]   addr_q, wdata_q, rdata_q, addr_sel, wdata_sel;
  logic            phase_end, lock_cur;

  assign phase_end = (cnt_q == '0);

`ifdef RTC_SEQ_LOCK_EN
  assign lock_cur = bus.lock[grant_id_q];
`else
  assign lock_cur = 1'b0;
`endif

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .clk    (clk),
    .rst_n  (reset),
    .req_i  (bus.req),
    .cur_i  (grant_id_q),
    .adv_i  (state_q == S_ACK),
    .lock_i (lock_cur),
    .idle_i (state_q == S_IDLE),
    .gnt_o  (gnt_oh),
    .idx_o  (gnt_idx)
  );

  // One-hot select of the winner's request fields.
  always_comb begin
    we_sel    = 1'b0;
    addr_sel  = '0;
    wdata_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_oh[i]) begin
        we_sel    = we_sel | bus.we[i];
        addr_sel  = addr_sel | bus.addr[i*DW +: DW];
        wdata_sel = wdata_sel | bus.wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (|bus.req) state_d = S_ARB;
      S_ARB: begin
        // A request withdrawn before arbitration just returns to idle.
        state_d = (|gnt_oh) ? S_ADDR : S_IDLE;
        cnt_d   = LOAD;
      end
      S_ADDR, S_GAP1, S_DATA, S_GAP2: begin
        if (phase_end) begin
          state_d = next_phase(state_q);
          cnt_d   = LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      grant_id_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_ARB) begin
        grant_id_q <= gnt_idx;
        we_q       <= we_sel;
        addr_q     <= addr_sel;
        wdata_q    <= wdata_sel;
      end
      if (state_q == S_DATA && !we_q && phase_end) rdata_q <= bus.ad_in;
    end
  end

  // Strobes decode straight from the state register so an async reset
  // parks the bus at idle levels without waiting for a clock.
  always_comb begin
    bus.a_d    = A_D_IDLE;
    bus.cs     = CS_IDLE;
    bus.rd     = RD_IDLE;
    bus.wr     = WR_IDLE;
    bus.ad_out = '0;
    bus.ad_oe  = 1'b0;
    bus.ack    = '0;
    case (state_q)
      S_ADDR: begin
        bus.a_d = 1'b0; bus.cs = 1'b0; bus.wr = 1'b0;
        bus.ad_out = addr_q; bus.ad_oe = 1'b1;
      end
      S_GAP1: begin
        // Address held on the bus through the gap for chip hold time.
        bus.a_d = 1'b0; bus.ad_out = addr_q; bus.ad_oe = 1'b1;
      end
      S_DATA: begin
        bus.cs = 1'b0;
        if (we_q) begin
          bus.wr = 1'b0; bus.ad_out = wdata_q; bus.ad_oe = 1'b1;
        end else begin
          bus.rd = 1'b0;
        end
      end
      S_ACK:   bus.ack[grant_id_q] = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.rdata    = rdata_q;
  assign bus.grant_id = grant_id_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
module tb_rtc_bus_sequencer;
  localparam int N = 4, DW = 8, T = 4;

  typedef struct {
    int         ch;
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    int         ack_cyc;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] pad = 8'h00;
  int total = 0, bad = 0, cyc = 0;
  exp_t sb[$];
  int pend[N];
  int lock_drop[N];

  always #5 clk = ~clk;

  rtc_bus_sequencer_if #(.N_CH(N), .DW(DW)) bus();
  assign bus.ad_in = pad;

  rtc_bus_sequencer #(.N_CH(N), .DW(DW), .T_PH(T)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int acnt, g1cnt, dcnt, g2cnt, wrl, rdl, oec, holdbad, both;
  logic [7:0] maddr, mdata;

  task automatic clr_mon();
    acnt = 0; g1cnt = 0; dcnt = 0; g2cnt = 0; wrl = 0; rdl = 0; oec = 0;
    holdbad = 0; both = 0; maddr = 8'h00; mdata = 8'h00;
  endtask

  initial begin
    exp_t e;
    clr_mon();
    forever begin
      @(negedge clk);
      if (!rst_n) clr_mon();
      else begin
        if (!bus.rd && !bus.wr) both = 1;
        if (!bus.cs && !bus.a_d) begin
          acnt++; maddr = bus.ad_out;
        end else if (!bus.cs && bus.a_d) begin
          dcnt++;
          if (!bus.wr) wrl++;
          if (!bus.rd) rdl++;
          if (bus.ad_oe) begin oec++; mdata = bus.ad_out; end
        end else if (acnt > 0 && dcnt == 0) begin
          g1cnt++;
          if (!(bus.ad_oe && bus.ad_out == maddr)) holdbad++;
        end else if (dcnt > 0 && bus.ack == '0) begin
          g2cnt++;
          if (bus.ad_oe) holdbad++;
        end
        if (bus.ack != '0) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_ack: got ack=%b want none (cycle %0d)", bus.ack, cyc);
          end else begin
            e = sb.pop_front();
            chk("ack_vec", 32'(bus.ack), 32'(1 << e.ch));
            chk("grant_id", 32'(bus.grant_id), 32'(e.ch));
            chk("busy_at_ack", 32'(bus.busy), 32'd1);
            chk("addr", 32'(maddr), 32'(e.addr));
            chk("addr_cycles", 32'(acnt), 32'(T));
            chk("gap1_cycles", 32'(g1cnt), 32'(T));
            chk("data_cycles", 32'(dcnt), 32'(T));
            chk("gap2_cycles", 32'(g2cnt), 32'(T));
            chk("gap_hold", 32'(holdbad), 32'd0);
            chk("rd_wr_overlap", 32'(both), 32'd0);
            if (e.we) begin
              chk("wr_low", 32'(wrl), 32'(T));
              chk("rd_low_on_write", 32'(rdl), 32'd0);
              chk("oe_on_write", 32'(oec), 32'(T));
              chk("wdata", 32'(mdata), 32'(e.data));
            end else begin
              chk("rd_low", 32'(rdl), 32'(T));
              chk("wr_low_on_read", 32'(wrl), 32'd0);
              chk("oe_on_read", 32'(oec), 32'd0);
              chk("rdata", 32'(bus.rdata), 32'(e.data));
            end
            if (e.ack_cyc >= 0) chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
          end
          clr_mon();
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_ch(input int ch, input logic w, input logic [7:0] a, input logic [7:0] d);
    bus.we[ch] = w;
    bus.addr[ch*DW +: DW] = a;
    bus.wdata[ch*DW +: DW] = d;
  endtask

  task automatic go(input int ch, input int n);
    pend[ch] = n;
    bus.req[ch] = 1'b1;
  endtask

  task automatic push(input int ch, input logic w, input logic [7:0] a, input logic [7:0] d, input int c);
    exp_t e;
    e.ch = ch; e.we = w; e.addr = a; e.data = d; e.ack_cyc = c;
    sb.push_back(e);
  endtask

  // Runs until every expected ack has arrived and all requests are dropped.
  task automatic wait_idle(input int budget);
    int k = 0;
    while ((sb.size() != 0 || bus.req != '0) && k < budget) begin
      @(negedge clk); #1;
      k++;
      for (int c = 0; c < N; c++) begin
        if (bus.ack[c]) begin
          pend[c]--;
          if (pend[c] <= 0) bus.req[c] = 1'b0;
          if (pend[c] == 1) lock_drop[c] = cyc + 3;
        end
`ifdef RTC_SEQ_LOCK_EN
        if (cyc == lock_drop[c]) bus.lock[c] = 1'b0;
`endif
      end
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int c0, k;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
`ifdef RTC_SEQ_LOCK_EN
    bus.lock = '0;
`endif
    for (int c = 0; c < N; c++) begin pend[c] = 0; lock_drop[c] = -1; end

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_d", 32'(bus.a_d), 32'd1);
    chk("rst_cs", 32'(bus.cs), 32'd1);
    chk("rst_rd", 32'(bus.rd), 32'd1);
    chk("rst_wr", 32'(bus.wr), 32'd1);
    chk("rst_ad_out", 32'(bus.ad_out), 32'd0);
    chk("rst_ad_oe", 32'(bus.ad_oe), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // single write ch0 (ptr 0 -> 1)
    @(posedge clk); #1;
    set_ch(0, 1'b1, 8'h21, 8'h45); go(0, 1);
    push(0, 1'b1, 8'h21, 8'h45, cyc + 18);
    wait_idle(100);

    // single read ch1 (ptr -> 2)
    @(posedge clk); #1;
    pad = 8'h59;
    set_ch(1, 1'b0, 8'h22, 8'h00); go(1, 1);
    push(1, 1'b0, 8'h22, 8'h59, cyc + 18);
    wait_idle(100);

    // reset during DATA of ch3 write; afterwards pointer is 0 so ch0 goes first
    @(posedge clk); #1;
    set_ch(3, 1'b1, 8'h27, 8'h80); set_ch(0, 1'b1, 8'h26, 8'h10);
    go(3, 1); go(0, 1);
    k = 0;
    while (!(!bus.cs && bus.a_d) && k < 40) begin @(negedge clk); k++; end
    chk("reach_data", 32'(k < 40), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", 32'(bus.cs), 32'd1);
    chk("mid_rst_wr", 32'(bus.wr), 32'd1);
    chk("mid_rst_rd", 32'(bus.rd), 32'd1);
    chk("mid_rst_a_d", 32'(bus.a_d), 32'd1);
    chk("mid_rst_ad_oe", 32'(bus.ad_oe), 32'd0);
    chk("mid_rst_ack", 32'(bus.ack), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_grant_id", 32'(bus.grant_id), 32'd0);
    chk("mid_rst_rdata", 32'(bus.rdata), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(0, 1'b1, 8'h26, 8'h10, cyc + 18);
    push(3, 1'b1, 8'h27, 8'h80, cyc + 37);
    wait_idle(200);

    // all four held: 0,1,2,3,0 (ptr 0 at start)
    @(posedge clk); #1;
    pad = 8'h5A;
    set_ch(0, 1'b1, 8'h20, 8'h30); set_ch(1, 1'b1, 8'h21, 8'h31);
    set_ch(2, 1'b0, 8'h23, 8'h00); set_ch(3, 1'b1, 8'h24, 8'h33);
    c0 = cyc;
    go(0, 2); go(1, 1); go(2, 1); go(3, 1);
    push(0, 1'b1, 8'h20, 8'h30, c0 + 18);
    push(1, 1'b1, 8'h21, 8'h31, c0 + 37);
    push(2, 1'b0, 8'h23, 8'h5A, c0 + 56);
    push(3, 1'b1, 8'h24, 8'h33, c0 + 75);
    push(0, 1'b1, 8'h20, 8'h30, c0 + 94);
    wait_idle(300);

    // ch2 drops req in GAP1, ch3 and ch0 join meanwhile (ptr 1 at start)
    @(posedge clk); #1;
    set_ch(2, 1'b1, 8'h25, 8'h44); set_ch(3, 1'b0, 8'h27, 8'h00);
    set_ch(0, 1'b1, 8'h22, 8'h46);
    c0 = cyc;
    go(2, 1);
    push(2, 1'b1, 8'h25, 8'h44, c0 + 18);
    repeat (7) @(posedge clk);
    #1;
    bus.req[2] = 1'b0;
    set_ch(2, 1'b1, 8'hEE, 8'hEE);
    go(3, 1); go(0, 1);
    push(3, 1'b0, 8'h27, 8'h5A, c0 + 37);
    push(0, 1'b1, 8'h22, 8'h46, c0 + 56);
    wait_idle(200);

`ifdef RTC_SEQ_LOCK_EN
    // ch1 locked for three writes while ch0 waits (ptr 1 at start)
    @(posedge clk); #1;
    set_ch(1, 1'b1, 8'h20, 8'h59); set_ch(0, 1'b1, 8'h21, 8'h07);
    bus.lock[1] = 1'b1;
    c0 = cyc;
    go(1, 3);
    push(1, 1'b1, 8'h20, 8'h59, c0 + 18);
    push(1, 1'b1, 8'h20, 8'h59, c0 + 37);
    push(1, 1'b1, 8'h20, 8'h59, c0 + 56);
    push(0, 1'b1, 8'h21, 8'h07, c0 + 75);
    repeat (3) @(posedge clk);
    #1;
    go(0, 1);
    wait_idle(300);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
